ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 118 +++++++++++
 tb/tb_ram_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter granting two requesters access to a single-port synchronous RAM.
// One acceptance per cycle; reads return two cycles after acceptance via a tagged response pipeline.
module ram_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_BUS_WIDTH = 4,
    parameter int MAX_MEM_LOC    = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      a_req,
    input  logic                      a_we,
    input  logic [ADDR_BUS_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]     a_wdata,
    input  logic                      b_req,
    input  logic                      b_we,
    input  logic [ADDR_BUS_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]     b_wdata,
    output logic                      a_gnt,
    output logic                      b_gnt,
    output logic                      a_rvalid,
    output logic                      b_rvalid,
    output logic [DATA_WIDTH-1:0]     a_rdata,
    output logic [DATA_WIDTH-1:0]     b_rdata,
    output logic                      a_err,
    output logic                      b_err,
    output logic                      ram_read_en,
    output logic                      ram_write_en,
    output logic [ADDR_BUS_WIDTH-1:0] ram_address_loc,
    output logic [DATA_WIDTH-1:0]     ram_data_in,
    input  logic [DATA_WIDTH-1:0]     ram_data_out
);

    typedef enum logic {SEL_A = 1'b0, SEL_B = 1'b1} sel_t;

    localparam logic [ADDR_BUS_WIDTH:0] MAX_LOC = (ADDR_BUS_WIDTH + 1)'(MAX_MEM_LOC);

    sel_t                      ptr;
    logic                      accept;
    logic                      sel_we;
    logic                      sel_oor;
    logic [ADDR_BUS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]     sel_wdata;

    // Issue-stage tags travelling alongside the RAM command.
    logic                      iss_valid;
    sel_t                      iss_id;
    logic                      iss_read;
    logic                      iss_oor;

    logic [DATA_WIDTH-1:0]     a_hold;
    logic [DATA_WIDTH-1:0]     b_hold;

    // Handshake: a request is accepted on a rising edge where req and gnt are both high;
    // the requester keeps req/we/addr/wdata stable until then. gnt is forced low in reset.
    always_comb begin
        a_gnt = rst_n & a_req & (~b_req | (ptr == SEL_A));
        b_gnt = rst_n & b_req & (~a_req | (ptr == SEL_B));
    end

    always_comb begin
        accept    = a_gnt | b_gnt;
        sel_we    = b_gnt ? b_we    : a_we;
        sel_addr  = b_gnt ? b_addr  : a_addr;
        sel_wdata = b_gnt ? b_wdata : a_wdata;
        sel_oor   = {1'b0, sel_addr} > MAX_LOC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr             <= SEL_A;
            ram_read_en     <= 1'b0;
            ram_write_en    <= 1'b0;
            ram_address_loc <= '0;
            ram_data_in     <= '0;
            iss_valid       <= 1'b0;
            iss_id          <= SEL_A;
            iss_read        <= 1'b0;
            iss_oor         <= 1'b0;
        end else begin
            ram_read_en  <= accept & ~sel_we & ~sel_oor;
            ram_write_en <= accept &  sel_we & ~sel_oor;
            iss_valid    <= accept;
            iss_id       <= b_gnt ? SEL_B : SEL_A;
            iss_read     <= ~sel_we;
            iss_oor      <= sel_oor;
            if (accept) begin
                ptr             <= b_gnt ? SEL_A : SEL_B;
                ram_address_loc <= sel_addr;
                ram_data_in     <= sel_wdata;
            end
        end
    end

    // Response stage: lines up with the cycle the RAM presents its registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_err    <= 1'b0;
            b_err    <= 1'b0;
            a_hold   <= '0;
            b_hold   <= '0;
        end else begin
            a_rvalid <= iss_valid & iss_read & ~iss_oor & (iss_id == SEL_A);
            b_rvalid <= iss_valid & iss_read & ~iss_oor & (iss_id == SEL_B);
            a_err    <= iss_valid & iss_oor & (iss_id == SEL_A);
            b_err    <= iss_valid & iss_oor & (iss_id == SEL_B);
            if (a_rvalid) a_hold <= ram_data_out;
            if (b_rvalid) b_hold <= ram_data_out;
        end
    end

    always_comb begin
        a_rdata = a_rvalid ? ram_data_out : a_hold;
        b_rdata = b_rvalid ? ram_data_out : b_hold;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic, checked against a
// transaction-level model (grant rule, reference memory, expected issue/response queues).
module tb_ram_arbiter;

    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int MAXL = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, a_err, b_err;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_read_en, ram_write_en;
    logic [AW-1:0] ram_address_loc;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out = '0;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .MAX_MEM_LOC(MAXL)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata), .a_err(a_err), .b_err(b_err),
        .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
        .ram_address_loc(ram_address_loc), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    // Environment RAM: registered read, one cycle after a read-enabled edge.
    logic [DW-1:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_write_en) ram_mem[ram_address_loc] <= ram_data_in;
        if (ram_read_en)  ram_data_out <= ram_mem[ram_address_loc];
    end

    typedef struct {
        int            due;
        logic          id;
        logic          we;
        logic          oor;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t          iss_q[$];
    txn_t          rsp_q[$];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] last_a, last_b;
    int            ref_ptr;
    int            cyc;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          ga, gb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, {a_gnt, b_gnt}, 0);
        check({tag, "_rvalid"}, {a_rvalid, b_rvalid}, 0);
        check({tag, "_err"}, {a_err, b_err}, 0);
        check({tag, "_en"}, {ram_read_en, ram_write_en}, 0);
        check({tag, "_addr"}, ram_address_loc, 0);
        check({tag, "_din"}, ram_data_in, 0);
        check({tag, "_rdata"}, {a_rdata, b_rdata}, 0);
    endtask

    task automatic model_reset();
        iss_q.delete();
        rsp_q.delete();
        ref_ptr = 0;
        last_a  = '0;
        last_b  = '0;
    endtask

    // Compares registered outputs for the current cycle against the expected queues.
    task automatic check_regs();
        txn_t          t;
        logic          e_we, e_re, e_av, e_bv, e_ae, e_be;
        logic [DW-1:0] e_ad, e_bd;
        e_we = 0; e_re = 0; e_av = 0; e_bv = 0; e_ae = 0; e_be = 0;
        e_ad = last_a;
        e_bd = last_b;
        if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
            t = iss_q.pop_front();
            e_we = t.we & ~t.oor;
            e_re = ~t.we & ~t.oor;
            if (e_we | e_re) check("ram_addr", ram_address_loc, t.addr);
            if (e_we) check("ram_din", ram_data_in, t.wdata);
        end
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            t = rsp_q.pop_front();
            if (t.oor) begin
                if (t.id) e_be = 1; else e_ae = 1;
            end else if (!t.we) begin
                if (t.id) begin e_bv = 1; e_bd = t.rdata; end
                else      begin e_av = 1; e_ad = t.rdata; end
            end
        end
        check("ram_write_en", ram_write_en, e_we);
        check("ram_read_en", ram_read_en, e_re);
        check("a_rvalid", a_rvalid, e_av);
        check("b_rvalid", b_rvalid, e_bv);
        check("a_err", a_err, e_ae);
        check("b_err", b_err, e_be);
        check("a_rdata", a_rdata, e_ad);
        check("b_rdata", b_rdata, e_bd);
        last_a = e_ad;
        last_b = e_bd;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check grants, model the next edge.
    task automatic cycle(input logic ar, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic br, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                         output logic acc_a, output logic acc_b);
        txn_t t;
        @(negedge clk);
        check_regs();
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #1;
        acc_a = ar && (!br || ref_ptr == 0);
        acc_b = br && (!ar || ref_ptr == 1);
        check("a_gnt", a_gnt, acc_a);
        check("b_gnt", b_gnt, acc_b);
        if (acc_a || acc_b) begin
            t.id    = acc_b;
            t.we    = acc_b ? bw : aw;
            t.addr  = acc_b ? ba : aa;
            t.wdata = acc_b ? bd : ad;
            t.oor   = int'(t.addr) > MAXL;
            t.rdata = ref_mem[t.addr];
            if (t.we && !t.oor) ref_mem[t.addr] = t.wdata;
            t.due = cyc + 1;
            iss_q.push_back(t);
            t.due = cyc + 2;
            rsp_q.push_back(t);
            ref_ptr = acc_b ? 0 : 1;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
    endtask

    // Random requesters that hold their request until granted.
    task automatic random_traffic(input int n, input int busy_pct);
        logic          pa, pb, paw, pbw;
        logic [AW-1:0] paa, pba;
        logic [DW-1:0] pad, pbd;
        pa = 0; pb = 0; paw = 0; pbw = 0; paa = '0; pba = '0; pad = '0; pbd = '0;
        for (int i = 0; i < n; i++) begin
            if (!pa && $urandom_range(1, 100) <= busy_pct) begin
                pa = 1; paw = 1'($urandom_range(0, 1)); paa = AW'($urandom_range(0, 11)); pad = DW'($urandom);
            end
            if (!pb && $urandom_range(1, 100) <= busy_pct) begin
                pb = 1; pbw = 1'($urandom_range(0, 1)); pba = AW'($urandom_range(0, 11)); pbd = DW'($urandom);
            end
            cycle(pa, paw, paa, pad, pb, pbw, pba, pbd, ga, gb);
            if (ga) pa = 0;
            if (gb) pb = 0;
        end
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        cyc = 0;
        model_reset();
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_clk");
        @(negedge clk);
        rst_n = 1'b1;

        // A-only writes to 1,2,3
        cycle(1, 1, 4'd1, 8'h11, 0, 0, 0, 0, ga, gb);
        cycle(1, 1, 4'd2, 8'h22, 0, 0, 0, 0, ga, gb);
        cycle(1, 1, 4'd3, 8'h33, 0, 0, 0, 0, ga, gb);
        idle(2);
        // A reads addr 2
        cycle(1, 0, 4'd2, 8'h00, 0, 0, 0, 0, ga, gb);
        idle(3);
        // B writes 5, A reads 5 on the next edge
        cycle(0, 0, 0, 0, 1, 1, 4'd5, 8'hA5, ga, gb);
        cycle(1, 0, 4'd5, 8'h00, 0, 0, 0, 0, ga, gb);
        idle(3);
        // Out-of-range read and write
        cycle(1, 0, 4'd12, 8'h00, 0, 0, 0, 0, ga, gb);
        idle(3);
        cycle(0, 0, 0, 0, 1, 1, 4'd15, 8'h5A, ga, gb);
        idle(3);
        // Boundary address: last valid location
        cycle(1, 1, 4'd9, 8'h99, 0, 0, 0, 0, ga, gb);
        cycle(0, 0, 0, 0, 1, 0, 4'd9, 8'h00, ga, gb);
        idle(3);

        // Reset while a read is in flight
        cycle(1, 0, 4'd2, 8'h00, 0, 0, 0, 0, ga, gb);
        @(negedge clk);
        check_regs();
        #2;
        rst_n = 1'b0;
        a_req = 1; b_req = 1;
        #1;
        check_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("midrst_clk");
        @(negedge clk);
        rst_n = 1'b1;
        a_req = 0; b_req = 0;

        // Both requesters continuously busy straight after reset
        random_traffic(40, 100);
        // General random traffic
        random_traffic(400, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
